map_tile_renderer: RTL and testbench
====================================

# map_tile_renderer

Pipelined, parametrised map-tile renderer for the Pacman playfield. It sits between the VGA timing generator and the pixel mux. It converts the current screen coordinate into a tile-map address, reads the tile code from the external map RAM, and emits 4:4:4 RGB for walls, pellets, blinking power pellets and the ghost door. It adds tile-size/map-size parameters, a frame-driven blink counter and a level-complete wall flash mode.

## Interface
- TILE_BITS, 3: log2 of tile edge T (T = 2**TILE_BITS); legal range 2..5.
- MAP_W, 28: map width in tiles.
- MAP_H, 31: map height in tiles.
- BLINK_FRAMES, 16: frames per blink half-period; legal range ≥ 1.
- WALL_COLOR, 12'h00F: wall RGB {R,G,B}.
- PELLET_COLOR, 12'hFB9: pellet and power-pellet RGB.
- DOOR_COLOR, 12'hFBF: ghost-door RGB.
- clk  in  1  pixel clock. Single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- flash_en  in  1  level-complete flash mode.
- pix_valid  in  1  sx/sy valid this cycle.
- sx, sy  in  10 each  screen pixel coordinate.
- map_addr  out  AW = $clog2(MAP_W*MAP_H)  map RAM read address. The RAM is synchronous with 1-cycle read latency.
- map_code  in  4  tile code returned by the RAM.
- R, G, B  out  4 each  pixel colour.
- rgb_valid  out  1  R/G/B correspond to a pix_valid input 3 cycles earlier.

## Operation
- Tile decode: col = sx >> TILE_BITS and row = sy >> TILE_BITS.
- In-tile position: fx = sx[TILE_BITS-1:0] and fy = sy[TILE_BITS-1:0]. Centre C = T/2.
- off_map = (col ≥ MAP_W) or (row ≥ MAP_H).
- map_addr = row*MAP_W + col, truncated to AW bits. map_addr = 0 when off_map.
- Tile codes (all other pixels in a tile are black):
  - 0: empty.
  - 1: horizontal wall, lit where fy==C.
  - 2: vertical wall, lit where fx==C.
  - 3: corner down-right, lit where (fy==C && fx≥C) or (fx==C && fy≥C).
  - 4: corner down-left, lit where (fy==C && fx≤C) or (fx==C && fy≥C).
  - 5: corner up-left, lit where (fy==C && fx≤C) or (fx==C && fy≤C).
  - 6: corner up-right, lit where (fy==C && fx≥C) or (fx==C && fy≤C).
  - 7: pellet, PELLET_COLOR where fx and fy are both in {C-1, C}.
  - 8: power pellet, PELLET_COLOR where fx and fy are both in [C-2, C+1] and blink_phase==0.
  - 9: ghost door, DOOR_COLOR where fy==C.
  - 10..15: empty.
- Wall colour:
  - WALL_COLOR when flash_en==0.
  - When flash_en==1: WALL_COLOR if blink_phase==0, 12'hFFF if blink_phase==1.
- Blink counter:
  - frame_cnt counts frame_start pulses from 0 to BLINK_FRAMES-1, then wraps to 0.
  - On each wrap, blink_phase toggles.
  - With BLINK_FRAMES=1, blink_phase toggles on every frame_start.
- Invalid or off-map input gives R=G=B=0. Off-map pixels render black regardless of map_code.

## Timing
- 3-stage pipeline. An input sampled in cycle t produces its output in cycle t+3.
  - Stage 1 (registered at end of t): map_addr, fx, fy, valid, off_map.
  - Stage 2: the RAM returns map_code during t+2. fx, fy, valid and off_map are delayed one more register to align with it.
  - Stage 3 (registered at end of t+2): R, G, B, rgb_valid.
- The pipeline runs every cycle with no stalls. pix_valid=0 cycles propagate as bubbles, with rgb_valid=0 and RGB=0 at output.
- blink_phase and flash_en are sampled at stage 3. A change affects pixels whose stage 3 occurs on or after the change.
- frame_start and pix_valid in the same cycle: the count updates and the pixel proceeds normally.
- Reset (asynchronous, any time including mid-frame):
  - map_addr, R, G, B, rgb_valid, frame_cnt, blink_phase and all pipeline valids go to 0 immediately.
  - In-flight pixels are discarded.
  - The first valid output appears 3 cycles after the first pix_valid following rst_n deassertion.

## Test plan
- Reset: assert rst_n=0 mid-stream → R/G/B = 0 and rgb_valid = 0 within the same cycle. Release, then drive pix_valid at cycle 0 → rgb_valid rises exactly at cycle 3.
- Horizontal wall: map code 1 at tile (0,0), TILE_BITS=3, sweep sx=0..7 at sy=4 → eight outputs of {F? no: R=0,G=0,B=F} (WALL_COLOR 12'h00F). Same sweep at sy=3 → all black. map_addr = 0.
- Corner and address: code 3 at col 5, row 2 → map_addr = 61. Pixel (44,20) → 12'h00F. Pixel (41,20) → black. Pixel (44,23) → 12'h00F.
- Power-pellet blink: BLINK_FRAMES=16, code 8, pixel fx=fy=4. After reset → 12'hFB9. After 16 frame_start pulses → 12'h000. After 32 pulses → 12'hFB9.
- Flash mode: flash_en=1 with a wall pixel → 12'h00F in phase 0 and 12'hFFF in phase 1. flash_en=0 → 12'h00F in both phases.
- Off-map and bubbles: sx=224 (col 28) with RAM returning code 1 → map_addr = 0 and output black. Alternating pix_valid 1/0 → rgb_valid shows the same alternating pattern delayed 3 cycles.

Source files
------------

// File: rtl/map_tile_renderer_if.sv
// Bus between the VGA timing side, the map RAM and the tile renderer.
// pix_valid qualifies sx/sy every cycle with no backpressure; rgb_valid marks R/G/B three cycles later.
interface map_tile_renderer_if #(
    parameter int AW = 10
);
    logic          frame_start;
    logic          flash_en;
    logic          pix_valid;
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic [AW-1:0] map_addr;
    logic [3:0]    map_code;
    logic [3:0]    R;
    logic [3:0]    G;
    logic [3:0]    B;
    logic          rgb_valid;

    modport master (
        output frame_start, flash_en, pix_valid, sx, sy, map_code,
        input  map_addr, R, G, B, rgb_valid
    );

    modport slave (
        input  frame_start, flash_en, pix_valid, sx, sy, map_code,
        output map_addr, R, G, B, rgb_valid
    );
endinterface

// File: rtl/map_tile_renderer.sv
// Three-stage tile renderer: coordinate -> map address -> tile code -> RGB,
// with a frame-driven blink phase for power pellets and level-complete wall flashing.
module map_tile_renderer #(
    parameter int          TILE_BITS    = 3,
    parameter int          MAP_W        = 28,
    parameter int          MAP_H        = 31,
    parameter int          BLINK_FRAMES = 16,
    parameter logic [11:0] WALL_COLOR   = 12'h00F,
    parameter logic [11:0] PELLET_COLOR = 12'hFB9,
    parameter logic [11:0] DOOR_COLOR   = 12'hFBF
) (
    input logic               clk,
    input logic               rst_n,
    map_tile_renderer_if.slave bus
);
    localparam int AW = $clog2(MAP_W * MAP_H);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TILE_BITS-1:0] C    = TILE_BITS'(1 << (TILE_BITS - 1));
    localparam logic [TILE_BITS-1:0] C_M1 = TILE_BITS'((1 << (TILE_BITS - 1)) - 1);
    localparam logic [TILE_BITS-1:0] C_M2 = TILE_BITS'((1 << (TILE_BITS - 1)) - 2);
    localparam logic [TILE_BITS-1:0] C_P1 = TILE_BITS'((1 << (TILE_BITS - 1)) + 1);
    localparam logic [9:0] MAP_W_L = 10'(MAP_W);
    localparam logic [9:0] MAP_H_L = 10'(MAP_H);

    // Stage 1: tile decode
    logic [9:0]           col, row;
    logic                 off_map;
    logic [AW-1:0]        lin;
    logic [AW-1:0]        addr_d, addr_q;
    logic [TILE_BITS-1:0] fx1_q, fy1_q, fx2_q, fy2_q;
    logic                 v1_q, v2_q, off1_q, off2_q;

    assign col     = bus.sx >> TILE_BITS;
    assign row     = bus.sy >> TILE_BITS;
    assign off_map = (col >= MAP_W_L) || (row >= MAP_H_L);
    assign lin     = AW'(row) * AW'(MAP_W) + AW'(col);
    assign addr_d  = off_map ? '0 : lin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            fx1_q  <= '0;
            fy1_q  <= '0;
            v1_q   <= 1'b0;
            off1_q <= 1'b0;
            fx2_q  <= '0;
            fy2_q  <= '0;
            v2_q   <= 1'b0;
            off2_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            fx1_q  <= bus.sx[TILE_BITS-1:0];
            fy1_q  <= bus.sy[TILE_BITS-1:0];
            v1_q   <= bus.pix_valid;
            off1_q <= off_map;
            // Stage 2 lines up with the RAM's one-cycle read latency.
            fx2_q  <= fx1_q;
            fy2_q  <= fy1_q;
            v2_q   <= v1_q;
            off2_q <= off1_q;
        end
    end

    // Blink counter
    logic [CW-1:0] frame_cnt_d, frame_cnt_q;
    logic          blink_d, blink_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (bus.frame_start) begin
            if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Stage 3: tile code to colour
    logic        h_c, v_c, in_pel, in_pwr, lit;
    logic [11:0] wall_rgb, rgb_d, rgb_q;
    logic        rgb_valid_q;

    assign h_c      = (fy2_q == C);
    assign v_c      = (fx2_q == C);
    assign in_pel   = ((fx2_q == C_M1) || (fx2_q == C)) && ((fy2_q == C_M1) || (fy2_q == C));
    assign in_pwr   = (fx2_q >= C_M2) && (fx2_q <= C_P1) && (fy2_q >= C_M2) && (fy2_q <= C_P1);
    assign wall_rgb = (bus.flash_en && blink_q) ? 12'hFFF : WALL_COLOR;

    always_comb begin
        lit = 1'b0;
        case (bus.map_code)
            4'd1:    lit = h_c;
            4'd2:    lit = v_c;
            4'd3:    lit = (h_c && fx2_q >= C) || (v_c && fy2_q >= C);
            4'd4:    lit = (h_c && fx2_q <= C) || (v_c && fy2_q >= C);
            4'd5:    lit = (h_c && fx2_q <= C) || (v_c && fy2_q <= C);
            4'd6:    lit = (h_c && fx2_q >= C) || (v_c && fy2_q <= C);
            default: lit = 1'b0;
        endcase
    end

    always_comb begin
        rgb_d = '0;
        if (v2_q && !off2_q) begin
            if (lit) begin
                rgb_d = wall_rgb;
            end else if (bus.map_code == 4'd7 && in_pel) begin
                rgb_d = PELLET_COLOR;
            end else if (bus.map_code == 4'd8 && in_pwr && !blink_q) begin
                rgb_d = PELLET_COLOR;
            end else if (bus.map_code == 4'd9 && h_c) begin
                rgb_d = DOOR_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= v2_q;
        end
    end

    assign bus.map_addr  = addr_q;
    assign bus.R         = rgb_q[11:8];
    assign bus.G         = rgb_q[7:4];
    assign bus.B         = rgb_q[3:0];
    assign bus.rgb_valid = rgb_valid_q;
endmodule

// File: tb/tb_map_tile_renderer.sv
// Directed and randomized checks of map_tile_renderer against a pixel-level reference model.
module tb_map_tile_renderer;
    localparam int TBITS = 3;
    localparam int TS    = 8;
    localparam int MW    = 28;
    localparam int MH    = 31;
    localparam int BF    = 16;

    // Clock and reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    map_tile_renderer_if #(.AW(10)) bus ();

    map_tile_renderer #(.TILE_BITS(TBITS), .MAP_W(MW), .MAP_H(MH), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Map RAM model, one-cycle read latency
    logic [3:0] mem [0:1023];
    always @(posedge clk) bus.map_code <= mem[bus.map_addr];

    typedef struct {
        bit v;
        int x;
        int y;
    } rec_t;

    rec_t        rec1, rec2;
    int          frames;
    int          tests = 0;
    int          fails = 0;
    logic [12:0] exp_q[$];

    // Reference model: colour of screen pixel (x,y) after nframes frame pulses
    function automatic logic [11:0] ref_pix(int x, int y, int nframes, bit fl);
        int col = x / TS;
        int row = y / TS;
        int fx  = x % TS;
        int fy  = y % TS;
        int c   = TS / 2;
        bit ph  = ((nframes / BF) % 2) == 1;
        bit h   = (fy == c);
        bit v   = (fx == c);
        logic [11:0] wall = (fl && ph) ? 12'hFFF : 12'h00F;
        logic [3:0]  code;
        if (col >= MW || row >= MH) return 12'h000;
        code = mem[row * MW + col];
        case (code)
            4'd1: return h ? wall : 12'h000;
            4'd2: return v ? wall : 12'h000;
            4'd3: return ((h && fx >= c) || (v && fy >= c)) ? wall : 12'h000;
            4'd4: return ((h && fx <= c) || (v && fy >= c)) ? wall : 12'h000;
            4'd5: return ((h && fx <= c) || (v && fy <= c)) ? wall : 12'h000;
            4'd6: return ((h && fx >= c) || (v && fy <= c)) ? wall : 12'h000;
            4'd7: return ((fx == c - 1 || fx == c) && (fy == c - 1 || fy == c)) ? 12'hFB9 : 12'h000;
            4'd8: return (fx >= c - 2 && fx <= c + 1 && fy >= c - 2 && fy <= c + 1 && !ph) ? 12'hFB9 : 12'h000;
            4'd9: return h ? 12'hFBF : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: one clock cycle of stimulus, with the output of the pixel from two steps back checked
    task automatic step(input bit v, input int x, input int y, input bit fs, input bit fl);
        logic [12:0] e;
        int          ea;
        @(negedge clk);
        bus.pix_valid   = v;
        bus.sx          = 10'(x);
        bus.sy          = 10'(y);
        bus.frame_start = fs;
        bus.flash_en    = fl;
        e = rec2.v ? {1'b1, ref_pix(rec2.x, rec2.y, frames, fl)} : 13'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("pixel", {19'd0, bus.rgb_valid, bus.R, bus.G, bus.B}, {19'd0, exp_q.pop_front()});
        if (v) begin
            ea = (x / TS >= MW || y / TS >= MH) ? 0 : (y / TS) * MW + x / TS;
            check("map_addr", {22'd0, bus.map_addr}, ea);
        end
        if (fs) frames++;
        rec2 = rec1;
        rec1 = '{v, x, y};
    endtask

    task automatic pix(input int x, input int y, input bit fl);
        step(1'b1, x, y, 1'b0, fl);
    endtask

    task automatic flush(input bit fl);
        repeat (3) step(1'b0, 0, 0, 1'b0, fl);
    endtask

    task automatic pulses(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset, checked before any clock edge passes
    task automatic do_reset(input string tag);
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.flash_en    = 1'b0;
        rst_n = 1'b0;
        #1;
        check(tag, {19'd0, bus.rgb_valid, bus.R, bus.G, bus.B}, 32'd0);
        check({tag, "_addr"}, {22'd0, bus.map_addr}, 32'd0);
        frames = 0;
        rec1   = '{1'b0, 0, 0};
        rec2   = '{1'b0, 0, 0};
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
        mem[0]  = 4'd1;
        mem[61] = 4'd3;
        mem[94] = 4'd8;
        bus.sx = '0;
        bus.sy = '0;
        #2;
        do_reset("reset_init");

        // Reset timing: first valid output exactly three cycles after the first pix_valid
        pix(4, 4, 1'b0);
        flush(1'b0);

        // Horizontal wall sweeps
        for (int x = 0; x < 8; x++) pix(x, 4, 1'b0);
        for (int x = 0; x < 8; x++) pix(x, 3, 1'b0);
        flush(1'b0);

        // Corner tile at col 5 row 2
        pix(44, 20, 1'b0);
        pix(41, 20, 1'b0);
        pix(44, 23, 1'b0);
        flush(1'b0);

        // Off-map column with RAM returning a wall code
        pix(224, 4, 1'b0);
        pix(300, 260, 1'b0);
        flush(1'b0);

        // Bubbles
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 4, 4, 1'b0, 1'b0);
        flush(1'b0);

        // Power pellet blink
        pix(84, 28, 1'b0);
        flush(1'b0);
        pulses(16);
        pix(84, 28, 1'b0);
        flush(1'b0);
        pulses(16);
        pix(84, 28, 1'b0);
        flush(1'b0);

        // Flash mode in both phases
        pix(4, 4, 1'b1);
        pix(4, 4, 1'b0);
        flush(1'b1);
        pulses(16);
        pix(4, 4, 1'b1);
        flush(1'b1);
        pix(4, 4, 1'b0);
        flush(1'b0);

        // Mid-stream reset with pixels in flight
        pix(4, 4, 1'b0);
        pix(5, 4, 1'b0);
        @(posedge clk);
        #3;
        do_reset("reset_mid");
        pix(4, 4, 1'b0);
        flush(1'b0);

        // Randomized map and stimulus
        for (int i = 0; i < MW * MH; i++) mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 300), $urandom_range(0, 270),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
        end
        flush(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
